// File: rtl/demux_sweep_ctrl_pkg.sv
// demux_sweep_ctrl_pkg
// Shared definitions for the demux sweep controller: the FSM state encoding
// and the mode constants. The FSM and the host both use the mode constants.
// No ports.
package demux_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic MODE_SWEEP  = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/demux_sweep_ctrl_if.sv
// demux_sweep_ctrl_if
// Groups the request and demux-drive signals of the sweep controller.
// Signals:
//   start, mode, dest, ch_ready : host/destination side -> controller
//   sel_o, data_o               : controller -> demux sel/data
//   busy, done, err             : controller status -> host
// Modports: master (host side), slave (controller side).
interface demux_sweep_ctrl_if #(
  parameter int N     = 8,
  parameter int SEL_W = 3
);
  logic             start;
  logic             mode;
  logic [SEL_W-1:0] dest;
  logic [N-1:0]     ch_ready;
  logic [SEL_W-1:0] sel_o;
  logic             data_o;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, mode, dest, ch_ready,
    input  sel_o, data_o, busy, done, err
  );

  modport slave (
    input  start, mode, dest, ch_ready,
    output sel_o, data_o, busy, done, err
  );
endinterface

// File: rtl/demux_pulse_timer.sv
// demux_pulse_timer
// Loadable down-counter with a zero flag. The controller uses it to time
// both the PULSE and GAP phases.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val this cycle (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; it holds at zero
//   zero       : count is zero
module demux_pulse_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/demux_sweep_ctrl.sv
// demux_sweep_ctrl
// Drives the sel/data inputs of a 1xN demux so that each selected output
// gets a PULSE_LEN-cycle data pulse followed by a GAP_LEN-cycle low gap.
// The controller waits for the channel's ready signal before each pulse.
// Mode 0 sweeps channels 0..N-1. Mode 1 pulses the single channel given by dest.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : demux_sweep_ctrl_if.slave (start/mode/dest/ch_ready in,
//                sel_o/data_o/busy/done/err out, all outputs registered)
// Optional feature macro: DEMUX_SWEEP_CONTINUOUS_EN
//   When defined, a mode-0 sweep wraps from N-1 back to 0 and pulses done
//   at each wrap. A start while busy then acts as a stop request that takes
//   effect at the end of the current channel's gap.
module demux_sweep_ctrl
  import demux_sweep_ctrl_pkg::*;
#(
  parameter int N         = 8,
  parameter int SEL_W     = 3,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_sweep_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(N - 1);
  localparam logic [SEL_W:0]   N_EXT      = (SEL_W + 1)'(N);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;

`ifdef DEMUX_SWEEP_CONTINUOUS_EN
  logic stop_q, stop_d;
  logic stop_now;
`endif

  demux_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = PULSE_LOAD;
    tmr_dec  = 1'b0;
`ifdef DEMUX_SWEEP_CONTINUOUS_EN
    // A stop request that arrives on the last gap cycle still counts.
    // Otherwise it is held until the gap ends.
    stop_now = stop_q | (bus.start & (mode_q == MODE_SWEEP));
    stop_d   = (state_q == ST_IDLE) ? 1'b0 : stop_now;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.mode == MODE_SWEEP) begin
            mode_d  = MODE_SWEEP;
            sel_d   = '0;
            state_d = ST_SETUP;
          end else if ({1'b0, bus.dest} < N_EXT) begin
            mode_d  = MODE_SINGLE;
            sel_d   = bus.dest;
            state_d = ST_SETUP;
          end else begin
            // An illegal destination leaves sel_o untouched.
            err_d = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (bus.ch_ready[sel_q]) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LOAD;
          state_d  = ST_PULSE;
        end
      end

      ST_PULSE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = ST_GAP;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_GAP: begin
        if (tmr_zero) begin
`ifdef DEMUX_SWEEP_CONTINUOUS_EN
          if ((mode_q == MODE_SWEEP) && !stop_now) begin
            state_d = ST_SETUP;
            if (sel_q == LAST_SEL) begin
              sel_d  = '0;
              done_d = 1'b1;
            end else begin
              sel_d = sel_q + 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
`else
          if ((mode_q == MODE_SWEEP) && (sel_q != LAST_SEL)) begin
            sel_d   = sel_q + 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // data_o and busy are decoded from the next state.
    // This keeps both outputs registered and glitch-free.
    data_d = (state_d == ST_PULSE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      mode_q  <= MODE_SWEEP;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef DEMUX_SWEEP_CONTINUOUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
    end
  end
`endif

  assign bus.sel_o  = sel_q;
  assign bus.data_o = data_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_demux_sweep_ctrl.sv
// tb_demux_sweep_ctrl
// Directed bench for demux_sweep_ctrl with PULSE_LEN=2 and GAP_LEN=3.
// It uses one N=8 instance and one N=6 instance; the N=6 instance
// exercises illegal destinations.
module tb_demux_sweep_ctrl;

  localparam int P   = 2;
  localparam int G   = 3;
  localparam int PER = 1 + P + G;

  logic clk = 1'b0;
  logic rst_n;

  int totalCount = 0;
  int badCount   = 0;

  always #5 clk = ~clk;

  demux_sweep_ctrl_if #(.N(8), .SEL_W(3)) bus8 ();
  demux_sweep_ctrl_if #(.N(6), .SEL_W(3)) bus6 ();

  demux_sweep_ctrl #(.N(8), .SEL_W(3), .PULSE_LEN(P), .GAP_LEN(G), .CNT_W(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  demux_sweep_ctrl #(.N(6), .SEL_W(3), .PULSE_LEN(P), .GAP_LEN(G), .CNT_W(8)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic m, input logic [2:0] d);
    bus8.start = s;
    bus8.mode  = m;
    bus8.dest  = d;
  endtask

  // Sweeps the N=8 instance. holdChan (>=0) keeps that channel's ready low
  // for holdLen extra SETUP cycles. stopAt (>=0) pulses start with a
  // different mode/dest at that cycle.
  task automatic runSweep(input int holdChan, input int holdLen, input int stopAt);
    int endK;
    int h;
    int kk;
    int lastSel;
    logic expData;
    h       = holdChan * PER;
    endK    = 8 * PER + ((holdChan >= 0) ? holdLen : 0);
    lastSel = 7;
`ifdef DEMUX_SWEEP_CONTINUOUS_EN
    if (stopAt >= 0) begin
      endK    = (stopAt / PER + 1) * PER;
      lastSel = stopAt / PER;
    end
`endif
    if (holdChan >= 0) bus8.ch_ready = ~(8'b1 << holdChan);
    applyStimulus(1'b1, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0);
    for (int k = 0; k < endK; k++) begin
      kk = k;
      if (holdChan >= 0 && k > h) kk = (k <= h + holdLen) ? h : k - holdLen;
      expData = ((kk % PER) >= 1) && ((kk % PER) <= P);
      checkOutput("sweep_sel", 32'(bus8.sel_o), 32'(kk / PER));
      checkOutput("sweep_data", 32'(bus8.data_o), 32'(expData));
      checkOutput("sweep_busy", 32'(bus8.busy), 32'd1);
      checkOutput("sweep_done_early", 32'(bus8.done), 32'd0);
      if (holdChan >= 0 && k == h + holdLen) bus8.ch_ready = 8'hFF;
      if (k == stopAt) applyStimulus(1'b1, 1'b1, 3'd2);
      tick();
      if (k == stopAt) applyStimulus(1'b0, 1'b0, 3'd0);
    end
    checkOutput("sweep_end_done", 32'(bus8.done), 32'd1);
    checkOutput("sweep_end_busy", 32'(bus8.busy), 32'd0);
    checkOutput("sweep_end_data", 32'(bus8.data_o), 32'd0);
    checkOutput("sweep_end_sel", 32'(bus8.sel_o), 32'(lastSel));
    tick();
    checkOutput("sweep_done_once", 32'(bus8.done), 32'd0);
    checkOutput("sweep_idle_busy", 32'(bus8.busy), 32'd0);
    checkOutput("sweep_hold_sel", 32'(bus8.sel_o), 32'(lastSel));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus8.start    = 1'b0;
    bus8.mode     = 1'b0;
    bus8.dest     = 3'd0;
    bus8.ch_ready = 8'hFF;
    bus6.start    = 1'b0;
    bus6.mode     = 1'b0;
    bus6.dest     = 3'd0;
    bus6.ch_ready = 6'h3F;
    #12;
    checkOutput("rst_sel", 32'(bus8.sel_o), 32'd0);
    checkOutput("rst_data", 32'(bus8.data_o), 32'd0);
    checkOutput("rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("rst_done", 32'(bus8.done), 32'd0);
    checkOutput("rst_err", 32'(bus8.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy", 32'(bus8.busy), 32'd0);

    $display("[TB] sweep");
    runSweep(-1, 0, -1);

    $display("[TB] single channel dest=5");
    applyStimulus(1'b1, 1'b1, 3'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0);
    for (int k = 0; k < PER; k++) begin
      checkOutput("single_sel", 32'(bus8.sel_o), 32'd5);
      checkOutput("single_data", 32'(bus8.data_o), 32'((k >= 1) && (k <= P)));
      checkOutput("single_busy", 32'(bus8.busy), 32'd1);
      tick();
    end
    checkOutput("single_done", 32'(bus8.done), 32'd1);
    checkOutput("single_end_busy", 32'(bus8.busy), 32'd0);
    tick();
    checkOutput("single_done_once", 32'(bus8.done), 32'd0);
    checkOutput("single_sel_hold", 32'(bus8.sel_o), 32'd5);

    $display("[TB] illegal dest on N=6");
    for (int d = 7; d >= 6; d--) begin
      bus6.start = 1'b1;
      bus6.mode  = 1'b1;
      bus6.dest  = 3'(d);
      tick();
      bus6.start = 1'b0;
      checkOutput("illegal_err", 32'(bus6.err), 32'd1);
      checkOutput("illegal_busy", 32'(bus6.busy), 32'd0);
      checkOutput("illegal_data", 32'(bus6.data_o), 32'd0);
      checkOutput("illegal_sel", 32'(bus6.sel_o), 32'd0);
      tick();
      checkOutput("illegal_err_once", 32'(bus6.err), 32'd0);
      checkOutput("illegal_busy2", 32'(bus6.busy), 32'd0);
      checkOutput("illegal_data2", 32'(bus6.data_o), 32'd0);
    end
    bus6.start = 1'b1;
    bus6.mode  = 1'b1;
    bus6.dest  = 3'd5;
    tick();
    bus6.start = 1'b0;
    checkOutput("legal_last_err", 32'(bus6.err), 32'd0);
    checkOutput("legal_last_busy", 32'(bus6.busy), 32'd1);
    checkOutput("legal_last_sel", 32'(bus6.sel_o), 32'd5);
    repeat (PER) tick();
    checkOutput("legal_last_done", 32'(bus6.done), 32'd1);

    $display("[TB] backpressure on channel 3");
    runSweep(3, 10, -1);

    $display("[TB] start while busy");
    runSweep(-1, 0, 10);

    $display("[TB] reset mid-pulse");
    applyStimulus(1'b1, 1'b0, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0);
    repeat (4 * PER + 1) tick();
    checkOutput("pre_rst_data", 32'(bus8.data_o), 32'd1);
    checkOutput("pre_rst_sel", 32'(bus8.sel_o), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_data", 32'(bus8.data_o), 32'd0);
    checkOutput("async_rst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("async_rst_sel", 32'(bus8.sel_o), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_busy", 32'(bus8.busy), 32'd0);
    runSweep(-1, 0, -1);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
